// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared layer sizes, quantization defaults and buffer state encoding
package nn_pkg;

    localparam int NN_NUM_NEURONS = 32;
    localparam int NN_WIDTH_IN    = 24;
    localparam int NN_WIDTH_Q     = 8;
    localparam int NN_SHIFT       = 7;
    localparam int NN_RELU_EN     = 1;

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] FULL    = 1'b1;

endpackage

// File: rtl/requant_unit.sv
// rtl/requant_unit.sv - combinational ReLU, round-half-up right shift and saturation
module requant_unit #(
    parameter int WIDTH_IN = nn_pkg::NN_WIDTH_IN,
    parameter int WIDTH_Q  = nn_pkg::NN_WIDTH_Q,
    parameter int SHIFT    = nn_pkg::NN_SHIFT,
    parameter int RELU_EN  = nn_pkg::NN_RELU_EN
) (
    input  logic signed [WIDTH_IN-1:0] in_data,
    output logic        [WIDTH_Q-1:0]  q_data
);

    // One guard bit keeps the rounding add from overflowing.
    localparam int W = WIDTH_IN + 1;
    localparam logic signed [W-1:0] HALF = W'(1) << (SHIFT - 1);
    localparam logic signed [W-1:0] UMAX = (W'(1) << WIDTH_Q) - W'(1);
    localparam logic signed [W-1:0] SMAX = (W'(1) << (WIDTH_Q - 1)) - W'(1);
    localparam logic signed [W-1:0] SMIN = ~SMAX;

    logic signed [W-1:0] ext;
    logic signed [W-1:0] relu;
    logic signed [W-1:0] shifted;

    always_comb begin
        ext     = {in_data[WIDTH_IN-1], in_data};
        relu    = ((RELU_EN != 0) && (ext < 0)) ? '0 : ext;
        shifted = (relu + HALF) >>> SHIFT;
        q_data  = shifted[WIDTH_Q-1:0];
        if (RELU_EN != 0) begin
            if (shifted > UMAX) begin
                q_data = UMAX[WIDTH_Q-1:0];
            end else if (shifted < 0) begin
                q_data = '0;
            end
        end else begin
            if (shifted > SMAX) begin
                q_data = SMAX[WIDTH_Q-1:0];
            end else if (shifted < SMIN) begin
                q_data = SMIN[WIDTH_Q-1:0];
            end
        end
    end

endmodule

// File: rtl/activation_requant_buffer.sv
// rtl/activation_requant_buffer.sv - requantizes neuron results into a flat next-layer input buffer
module activation_requant_buffer
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = NN_NUM_NEURONS,
    parameter int WIDTH_IN    = NN_WIDTH_IN,
    parameter int WIDTH_Q     = NN_WIDTH_Q,
    parameter int SHIFT       = NN_SHIFT,
    parameter int RELU_EN     = NN_RELU_EN,
    parameter int CW          = $clog2(NUM_NEURONS + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             in_valid,
    input  logic signed [WIDTH_IN-1:0]       in_data,
    output logic [WIDTH_Q*NUM_NEURONS-1:0]   out_data,
    output logic                             out_valid,
    output logic [CW-1:0]                    count,
    output logic                             overrun
);

    logic [0:0]                     state_q, state_d;
    logic [CW-1:0]                  count_q, count_d;
    logic [WIDTH_Q*NUM_NEURONS-1:0] data_q, data_d;
    logic                           overrun_q, overrun_d;
    logic [WIDTH_Q-1:0]             q_data;

    requant_unit #(
        .WIDTH_IN (WIDTH_IN),
        .WIDTH_Q  (WIDTH_Q),
        .SHIFT    (SHIFT),
        .RELU_EN  (RELU_EN)
    ) u_requant (
        .in_data (in_data),
        .q_data  (q_data)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        // clear outranks a coincident input, which is simply dropped.
        if (clear) begin
            state_d   = COLLECT;
            count_d   = '0;
            data_d    = '0;
            overrun_d = 1'b0;
        end else if (in_valid) begin
            if (state_q == FULL) begin
                overrun_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_NEURONS; i++) begin
                    if (count_q == CW'(i)) begin
                        data_d[i*WIDTH_Q +: WIDTH_Q] = q_data;
                    end
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(NUM_NEURONS - 1)) begin
                    state_d = FULL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= COLLECT;
            count_q   <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = (state_q == FULL);
    assign count     = count_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_activation_requant_buffer.sv
// tb/tb_activation_requant_buffer.sv - directed self-checking bench for activation_requant_buffer
module tb_activation_requant_buffer;

    logic               clk = 1'b0;
    logic               reset;
    logic               clear;
    logic               in_valid;
    logic signed [23:0] in_data;
    logic [31:0]        out_data, out_data_s;
    logic               out_valid, out_valid_s;
    logic [2:0]         count, count_s;
    logic               overrun, overrun_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    activation_requant_buffer #(
        .NUM_NEURONS(4), .WIDTH_IN(24), .WIDTH_Q(8), .SHIFT(7), .RELU_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .out_data(out_data), .out_valid(out_valid), .count(count), .overrun(overrun)
    );

    activation_requant_buffer #(
        .NUM_NEURONS(4), .WIDTH_IN(24), .WIDTH_Q(8), .SHIFT(7), .RELU_EN(0)
    ) dut_signed (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .out_data(out_data_s), .out_valid(out_valid_s), .count(count_s), .overrun(overrun_s)
    );

    task automatic send(input logic signed [23:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (out_data !== 32'h0 || count !== 3'd0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL %s: data=%h count=%0d valid=%b overrun=%b, required all zero",
                     name, out_data, count, out_valid, overrun);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_empty("reset");
    endtask

    task automatic test_quant();
        logic signed [23:0] vin [4] = '{24'sd1000, -24'sd500, 24'sd40000, 24'sd64};
        logic [7:0]         vexp[4] = '{8'd8, 8'd0, 8'd255, 8'd1};
        for (int i = 0; i < 4; i++) begin
            send(vin[i]);
            checks++;
            if (count !== 3'(i + 1) || out_data[8*i +: 8] !== vexp[i]) begin
                errors++;
                $display("FAIL quant[%0d]: count=%0d elem=%h, required count=%0d elem=%h",
                         i, count, out_data[8*i +: 8], i + 1, vexp[i]);
            end
            checks++;
            if (out_valid !== (i == 3)) begin
                errors++;
                $display("FAIL quant_valid[%0d]: out_valid=%b, required %b", i, out_valid, i == 3);
            end
        end
        checks++;
        if (out_data !== 32'h01FF0008) begin
            errors++;
            $display("FAIL quant_data: out_data=%h, required 01ff0008", out_data);
        end
    endtask

    task automatic test_overrun();
        send(24'sd5000);
        checks++;
        if (out_data !== 32'h01FF0008 || overrun !== 1'b1 || count !== 3'd4 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun: data=%h overrun=%b count=%0d valid=%b, required 01ff0008 1 4 1",
                     out_data, overrun, count, out_valid);
        end
        @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: overrun=%b, required 1", overrun);
        end
        do_clear();
        check_empty("overrun_clear");
    endtask

    task automatic test_rounding();
        logic signed [23:0] vin [3] = '{24'sd63, 24'sd191, 24'sd192};
        logic [7:0]         vexp[3] = '{8'd0, 8'd1, 8'd2};
        for (int i = 0; i < 3; i++) send(vin[i]);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_data[8*i +: 8] !== vexp[i]) begin
                errors++;
                $display("FAIL rounding[%0d]: elem=%h, required %h", i, out_data[8*i +: 8], vexp[i]);
            end
        end
        do_clear();
    endtask

    task automatic test_clear_collide();
        send(24'sd1000);
        send(24'sd1000);
        clear = 1'b1;
        send(24'sd1000);
        clear = 1'b0;
        check_empty("clear_collide");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) send(24'sd1000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_empty("reset_mid");
        for (int i = 0; i < 4; i++) send(24'sd128);
        checks++;
        if (out_data !== 32'h01010101 || out_valid !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("FAIL reset_refill: data=%h valid=%b count=%0d, required 01010101 1 4",
                     out_data, out_valid, count);
        end
        do_clear();
    endtask

    task automatic test_relu_off();
        logic signed [23:0] vin [3] = '{-24'sd500, -24'sd40000, 24'sd40000};
        logic [7:0]         vexp[3] = '{8'hFC, 8'h80, 8'h7F};
        for (int i = 0; i < 3; i++) send(vin[i]);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_data_s[8*i +: 8] !== vexp[i]) begin
                errors++;
                $display("FAIL relu_off[%0d]: elem=%h, required %h", i, out_data_s[8*i +: 8], vexp[i]);
            end
        end
        checks++;
        if (count_s !== 3'd3 || out_valid_s !== 1'b0) begin
            errors++;
            $display("FAIL relu_off_count: count=%0d valid=%b, required 3 0", count_s, out_valid_s);
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        test_reset();
        test_quant();
        test_overrun();
        test_rounding();
        test_clear_collide();
        test_reset_mid();
        test_relu_off();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/activation_requant_buffer.md
Name: activation_requant_buffer

Overview:
Downstream stage of the layer's neuron units. Consumes each neuron's wide signed accumulator result on its done pulse. Applies ReLU, rounding right-shift and saturation down to the next layer's input width. Collects the results into a flattened buffer that is wired directly as the next layer's `in_data`, and flags when the layer is complete.

Parameters:
- NUM_NEURONS, 32: number of results collected per layer; sets the buffer depth.
- WIDTH_IN, 24: bit width of the incoming signed neuron result.
- WIDTH_Q, 8: bit width of each quantized stored element.
- SHIFT, 7: arithmetic right-shift (fixed-point rescale); must be ≥1 and < WIDTH_IN.
- RELU_EN, 1: 1 = ReLU with unsigned saturation; 0 = no ReLU, signed saturation.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- clear, input, 1: start a new layer; empties the buffer.
- in_valid, input, 1: one-cycle pulse, driven by the neuron's done signal.
- in_data, input, WIDTH_IN: signed neuron result; sampled only when in_valid=1.
- out_data, output, WIDTH_Q*NUM_NEURONS: flattened buffer; element i occupies [(i+1)*WIDTH_Q-1 -: WIDTH_Q].
- out_valid, output, 1: level signal; high when all NUM_NEURONS elements are stored.
- count, output, $clog2(NUM_NEURONS+1): number of elements stored so far.
- overrun, output, 1: sticky flag; an input arrived while the buffer was full.

Behaviour:
- Reset values: reset is synchronous and active-high on clk.
  - out_data = 0, count = 0, out_valid = 0, overrun = 0, state = COLLECT.
- States:
  - COLLECT: accepting inputs.
  - FULL: buffer complete; out_valid=1.
- Transitions:
  - COLLECT→FULL on the edge that writes element NUM_NEURONS-1.
  - FULL→COLLECT on clear.
  - Any state→COLLECT on reset.
- Write timing: in_valid high in cycle t → element[count] is updated, and count incremented, on the t→t+1 edge. Both are visible in cycle t+1. Single-cycle latency; back-to-back in_valid pulses are accepted every cycle.
- out_valid rises in the same cycle that count reaches NUM_NEURONS. It holds until clear or reset.
- Arithmetic, evaluated in WIDTH_IN+1 bits signed:
  - r = in_data; if RELU_EN and r<0, r = 0.
  - r = (r + 2^(SHIFT-1)) >>> SHIFT (round half up).
  - RELU_EN=1: saturate to [0, 2^WIDTH_Q-1].
  - RELU_EN=0: saturate to [-2^(WIDTH_Q-1), 2^(WIDTH_Q-1)-1], two's complement.
- Fill order: elements are written in arrival order, starting at index 0. The write index never wraps.
- in_valid while in FULL: the input is dropped, the buffer is unchanged, and overrun is set. overrun stays set until clear or reset.
- clear (any state): on the next edge, out_data = 0, count = 0, out_valid = 0, overrun = 0.
- clear and in_valid in the same cycle: clear wins and the input is dropped.
- Reset mid-collection: all partial data is discarded; values as for reset above.
- Non-selected buffer elements hold their value; there is no shifting.

Decomposition:
- Shared package nn_pkg:
  - WIDTH_Q and SHIFT defaults.
  - Layer sizes.
  - The state encoding constants COLLECT and FULL.
- One natural sub-module: requant_unit, purely combinational, performing ReLU, rounding shift and saturation. It is parameterised by WIDTH_IN, WIDTH_Q, SHIFT and RELU_EN and is reusable by other layers.

Test Plan:
All scenarios use NUM_NEURONS=4, SHIFT=7, WIDTH_Q=8, RELU_EN=1 unless stated.
- Quantization values: in_data 1000, -500, 40000, 64 on consecutive cycles.
  - Elements are 8, 0, 255, 1.
  - count steps 1..4; out_valid is high from the cycle after the 4th pulse.
  - out_data = 0x01FF0008.
- Rounding boundary: in_data 63 stores 0; in_data 191 stores 1; in_data 192 stores 2.
- Overrun: after the buffer is full, pulse in_valid with 5000.
  - out_data is unchanged and overrun=1.
  - A subsequent clear gives count=0, out_valid=0, overrun=0, out_data=0.
- Simultaneous clear and in_valid (in_data=1000) after 2 stored elements:
  - count=0, out_data=0; the 1000 is not stored.
- Reset mid-collection: after 3 elements, assert reset for 1 cycle.
  - All outputs are zero.
  - Then 4 fresh inputs of 128 fill the buffer: out_data=0x01010101, out_valid=1.
- RELU_EN=0: in_data -500 stores 0xFC (-4); in_data -40000 stores 0x80 (-128); in_data 40000 stores 0x7F.
